// File: rtl/pixel_stream_sequencer.sv
// Streams one N x N frame onto the kernel bus (write pass), then sweeps the
// bus with kern_we=0 and writes each returned result pixel to the result frame.
module pixel_stream_sequencer #(
   parameter int N           = 8,
   parameter int bitSize     = 6,
   parameter int pixelWidth  = 8,
   parameter int BEAT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [bitSize:0]      frame_rd_addr,
   input  logic [pixelWidth-1:0] frame_rd_data,
   output logic                  kern_we,
   output logic [bitSize:0]      kern_addr,
   output logic [pixelWidth-1:0] kern_data,
   input  logic [pixelWidth-1:0] result_in,
   output logic                  wb_we,
   output logic [bitSize:0]      wb_addr,
   output logic [pixelWidth-1:0] wb_data,
   output logic                  busy,
   output logic                  done
);

   localparam int              LAST_I   = N*N-1;
   localparam logic [bitSize:0] LAST    = LAST_I[bitSize:0];
   localparam int              BW       = (BEAT_CYCLES > 2) ?
                                          $clog2(BEAT_CYCLES) : 1;
   localparam logic [BW-1:0]   BEAT_END = BW'(BEAT_CYCLES-1);
   localparam logic [BW-1:0]   BEAT_PRE = BW'(BEAT_CYCLES-2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFETCH,
      S_WRITE,
      S_READ,
      S_FINISH
   } state_t;

   state_t                r_state;
   logic [BW-1:0]         r_beat;
   logic [bitSize:0]      r_addr;
   logic [bitSize:0]      r_frd;
   logic [bitSize:0]      r_kern_addr;
   logic                  r_kern_we;
   logic                  r_wb_we;
   logic [bitSize:0]      r_wb_addr;
   logic [pixelWidth-1:0] r_wb_data;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_drain;

   logic                  w_beat_end;
   logic                  w_last;
   logic [bitSize:0]      w_addr_nx;

   assign w_beat_end = (r_beat == BEAT_END);
   assign w_last     = (r_addr == LAST);
   assign w_addr_nx  = r_addr + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_addr      <= '0;
         r_frd       <= '0;
         r_kern_addr <= '0;
         r_kern_we   <= 1'b0;
         r_wb_we     <= 1'b0;
         r_wb_addr   <= '0;
         r_wb_data   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_drain     <= 1'b0;
      end else begin
         r_wb_we <= 1'b0;
         r_done  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_PREFETCH;
                  r_busy  <= 1'b1;
                  r_frd   <= '0;
               end
            end
            S_PREFETCH: begin
               r_state     <= S_WRITE;
               r_kern_we   <= 1'b1;
               r_kern_addr <= '0;
               r_beat      <= '0;
               r_addr      <= '0;
            end
            S_WRITE: begin
               // next pixel address lands on the last clock of this beat
               if (r_beat == BEAT_PRE && !w_last)
                  r_frd <= w_addr_nx;
               if (w_beat_end) begin
                  r_beat <= '0;
                  if (w_last) begin
                     r_state     <= S_READ;
                     r_kern_we   <= 1'b0;
                     r_addr      <= '0;
                     r_kern_addr <= '0;
                  end else begin
                     r_addr      <= w_addr_nx;
                     r_kern_addr <= w_addr_nx;
                  end
               end else begin
                  r_beat <= r_beat + 1'b1;
               end
            end
            S_READ: begin
               // one trailing clock lets the final result write land
               if (r_drain) begin
                  r_state     <= S_FINISH;
                  r_drain     <= 1'b0;
                  r_done      <= 1'b1;
                  r_busy      <= 1'b0;
                  r_kern_addr <= '0;
               end else if (w_beat_end) begin
                  r_wb_we   <= 1'b1;
                  r_wb_addr <= r_addr;
                  r_wb_data <= result_in;
                  r_beat    <= '0;
                  if (w_last) begin
                     r_drain <= 1'b1;
                  end else begin
                     r_addr      <= w_addr_nx;
                     r_kern_addr <= w_addr_nx;
                  end
               end else begin
                  r_beat <= r_beat + 1'b1;
               end
            end
            S_FINISH: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign frame_rd_addr = r_frd;
   assign kern_we       = r_kern_we;
   assign kern_addr     = r_kern_addr;
   assign kern_data     = r_kern_we ? frame_rd_data : '0;
   assign wb_we         = r_wb_we;
   assign wb_addr       = r_wb_addr;
   assign wb_data       = r_wb_data;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// Directed bench: 8x8/2-clk beat instance and a 4x4/3-clk beat instance,
// cycle-by-cycle comparison against hand-derived bus timing.
module tb_pixel_stream_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;

   logic [6:0] frd_a, kaddr_a, wba_a;
   logic [7:0] rd_a, kdata_a, rin_a, wbd_a;
   logic       kwe_a, wbwe_a, busy_a, done_a;

   logic [3:0] frd_b, kaddr_b, wba_b;
   logic [7:0] rd_b, kdata_b, rin_b, wbd_b;
   logic       kwe_b, wbwe_b, busy_b, done_b;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // frame[k] = k+1, sync read
   always @(posedge clk) rd_a <= 8'(frd_a) + 8'd1;
   always @(posedge clk) rd_b <= 8'(frd_b) + 8'd1;
   assign rin_a = 8'hA0 ^ {1'b0, kaddr_a};
   assign rin_b = 8'hA0 ^ {4'b0, kaddr_b};

   pixel_stream_sequencer u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .frame_rd_addr(frd_a), .frame_rd_data(rd_a),
      .kern_we(kwe_a), .kern_addr(kaddr_a), .kern_data(kdata_a),
      .result_in(rin_a), .wb_we(wbwe_a), .wb_addr(wba_a),
      .wb_data(wbd_a), .busy(busy_a), .done(done_a)
   );

   pixel_stream_sequencer #(
      .N(4), .bitSize(3), .pixelWidth(8), .BEAT_CYCLES(3)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .frame_rd_addr(frd_b), .frame_rd_data(rd_b),
      .kern_we(kwe_b), .kern_addr(kaddr_b), .kern_data(kdata_b),
      .result_in(rin_b), .wb_we(wbwe_b), .wb_addr(wba_b),
      .wb_data(wbd_b), .busy(busy_b), .done(done_b)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_start(input bit sel, input logic v);
      if (sel) start_b = v;
      else     start_a = v;
   endtask

   task automatic run(input bit sel, input int nn, input int bc,
                      input bit poke);
      int we_s, re_s, fin, k, ph;
      int e_busy, e_done, e_kwe, e_kaddr, e_kdata, e_frd, e_wb, e_wba;
      we_s = 2 + nn*bc;
      re_s = we_s + nn*bc;
      fin  = re_s + 1;
      @(negedge clk);
      set_start(sel, 1'b1);
      for (int t = 1; t <= fin; t++) begin
         @(negedge clk);
         if (t == 1) set_start(sel, 1'b0);
         if (poke && t == fin/2) set_start(sel, 1'b1);
         if (poke && t == fin/2 + 1) set_start(sel, 1'b0);
         e_busy = int'(t < fin);
         e_done = int'(t == fin);
         e_kwe = 0; e_kaddr = 0; e_kdata = 0; e_frd = nn-1;
         e_wb = 0; e_wba = 0;
         if (t == 1) begin
            e_frd = 0;
         end else if (t < we_s) begin
            k = (t-2)/bc; ph = (t-2)%bc;
            e_kwe = 1; e_kaddr = k; e_kdata = k+1;
            e_frd = (ph == bc-1) ? ((k+1 < nn) ? k+1 : nn-1) : k;
         end else if (t < re_s) begin
            e_kaddr = (t-we_s)/bc;
         end else if (t == re_s) begin
            e_kaddr = nn-1;
         end
         if (t > we_s && t <= re_s && (t-we_s)%bc == 0) begin
            e_wb = 1; e_wba = (t-we_s)/bc - 1;
         end
         chk($sformatf("busy@%0d", t),
             int'(sel ? busy_b : busy_a), e_busy);
         chk($sformatf("done@%0d", t),
             int'(sel ? done_b : done_a), e_done);
         chk($sformatf("kern_we@%0d", t),
             int'(sel ? kwe_b : kwe_a), e_kwe);
         chk($sformatf("kern_addr@%0d", t),
             sel ? int'(kaddr_b) : int'(kaddr_a), e_kaddr);
         chk($sformatf("kern_data@%0d", t),
             sel ? int'(kdata_b) : int'(kdata_a), e_kdata);
         chk($sformatf("frame_rd_addr@%0d", t),
             sel ? int'(frd_b) : int'(frd_a), e_frd);
         chk($sformatf("wb_we@%0d", t),
             int'(sel ? wbwe_b : wbwe_a), e_wb);
         if (e_wb == 1) begin
            chk($sformatf("wb_addr@%0d", t),
                sel ? int'(wba_b) : int'(wba_a), e_wba);
            chk($sformatf("wb_data@%0d", t),
                sel ? int'(wbd_b) : int'(wbd_a), 32'hA0 ^ e_wba);
         end
         if (poke && t == fin) set_start(sel, 1'b1);
      end
      if (poke) begin
         @(negedge clk);
         set_start(sel, 1'b0);
         chk("tail_busy", int'(sel ? busy_b : busy_a), 0);
         chk("tail_kern_we", int'(sel ? kwe_b : kwe_a), 0);
         chk("tail_frd", sel ? int'(frd_b) : int'(frd_a), nn-1);
      end
   endtask

   task automatic chk_idle_a(input string tag);
      chk({tag, "_busy"}, int'(busy_a), 0);
      chk({tag, "_done"}, int'(done_a), 0);
      chk({tag, "_kern_we"}, int'(kwe_a), 0);
      chk({tag, "_kern_addr"}, int'(kaddr_a), 0);
      chk({tag, "_kern_data"}, int'(kdata_a), 0);
      chk({tag, "_wb_we"}, int'(wbwe_a), 0);
      chk({tag, "_frd"}, int'(frd_a), 0);
   endtask

   initial begin
      bit seen;
      repeat (3) @(negedge clk);
      chk_idle_a("rst");
      chk("rst_b_busy", int'(busy_b), 0);
      chk("rst_b_kern_we", int'(kwe_b), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_idle_a("post_rst");

      run(1'b0, 64, 2, 1'b1);
      repeat (3) @(negedge clk);
      run(1'b0, 64, 2, 1'b0);
      run(1'b0, 64, 2, 1'b0);

      run(1'b1, 16, 3, 1'b1);
      run(1'b1, 16, 3, 1'b0);

      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (kwe_a && kaddr_a == 7'd10) seen = 1'b1;
      end
      chk("beat10_reached", int'(seen), 1);
      rst_n = 1'b0;
      #1;
      chk("async_kern_we", int'(kwe_a), 0);
      chk("async_wb_we", int'(wbwe_a), 0);
      chk("async_busy", int'(busy_a), 0);
      chk("async_kern_data", int'(kdata_a), 0);
      repeat (3) @(negedge clk);
      chk_idle_a("hold_rst");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk_idle_a("after_abort");

      run(1'b0, 64, 2, 1'b0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
